// File: rtl/vc_fifo.sv
// Multi-channel input buffer: NUM_VC independent circular FIFOs with one shared push
// port, one shared pop port, per-channel status decode and sticky error flags.
module vc_fifo #(
  parameter int DSIZE      = 4,
  parameter int DEPTH_LOG2 = 3,
  parameter int NUM_VC     = 2,
  parameter int VC_LOG2    = 1,
  parameter int AFULL_LVL  = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               write,
  input  logic [VC_LOG2-1:0] write_vc,
  input  logic [DSIZE-1:0]   item_in,
  input  logic               read,
  input  logic [VC_LOG2-1:0] read_vc,
  output logic [DSIZE-1:0]   item_out,
  output logic [NUM_VC-1:0]  full,
  output logic [NUM_VC-1:0]  empty,
  output logic [NUM_VC-1:0]  almost_full,
  output logic               overflow,
  output logic               underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LP_DEPTH = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LP_AFULL = (DEPTH_LOG2+1)'(AFULL_LVL);
  localparam logic [DEPTH_LOG2:0]   LP_CNT1  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] LP_PTR1  = DEPTH_LOG2'(1);
  localparam logic [VC_LOG2:0]      LP_NVC   = (VC_LOG2+1)'(NUM_VC);

  logic [DSIZE-1:0]      r_mem    [NUM_VC][DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr [NUM_VC];
  logic [DEPTH_LOG2-1:0] r_rd_ptr [NUM_VC];
  logic [DEPTH_LOG2:0]   r_count  [NUM_VC];
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_wvc_ok;
  logic                  w_rvc_ok;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic                  w_push_bad;
  logic                  w_pop_bad;
  logic [NUM_VC-1:0]     w_full;
  logic [NUM_VC-1:0]     w_empty;
  logic [NUM_VC-1:0]     w_afull;
  logic [NUM_VC-1:0]     w_push;
  logic [NUM_VC-1:0]     w_pop;

  assign w_wvc_ok = ({1'b0, write_vc} < LP_NVC);
  assign w_rvc_ok = ({1'b0, read_vc} < LP_NVC);

  always_comb begin
    w_full  = '0;
    w_empty = '0;
    w_afull = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      w_full[v]  = (r_count[v] == LP_DEPTH);
      w_empty[v] = (r_count[v] == '0);
      w_afull[v] = (r_count[v] >= LP_AFULL);
    end
  end

  // Accept decisions use pre-edge status only, so a pop never frees a slot for a same-edge push.
  assign w_push_ok  = write & w_wvc_ok & ~w_full[write_vc];
  assign w_pop_ok   = read  & w_rvc_ok & ~w_empty[read_vc];
  assign w_push_bad = write & w_wvc_ok &  w_full[write_vc];
  assign w_pop_bad  = read  & w_rvc_ok &  w_empty[read_vc];

  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      w_push[v] = w_push_ok & (write_vc == VC_LOG2'(v));
      w_pop[v]  = w_pop_ok  & (read_vc  == VC_LOG2'(v));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_wr_ptr[v] <= '0;
        r_rd_ptr[v] <= '0;
        r_count[v]  <= '0;
      end
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_push[v]) r_wr_ptr[v] <= r_wr_ptr[v] + LP_PTR1;
        if (w_pop[v])  r_rd_ptr[v] <= r_rd_ptr[v] + LP_PTR1;
        case ({w_push[v], w_pop[v]})
          2'b10:   r_count[v] <= r_count[v] + LP_CNT1;
          2'b01:   r_count[v] <= r_count[v] - LP_CNT1;
          default: r_count[v] <= r_count[v];
        endcase
      end
      if (w_push_bad) r_overflow  <= 1'b1;
      if (w_pop_bad)  r_underflow <= 1'b1;
    end
  end

  // Storage is deliberately left unreset; counts/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[write_vc][r_wr_ptr[write_vc]] <= item_in;
  end

  always_comb begin
    item_out = '0;
    if (w_rvc_ok && !w_empty[read_vc]) item_out = r_mem[read_vc][r_rd_ptr[read_vc]];
  end

  assign full        = w_full;
  assign empty       = w_empty;
  assign almost_full = w_afull;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_vc_fifo.sv
// Directed self-checking bench for vc_fifo with default parameters (2 VCs x 8 items x 4 bits).
module tb_vc_fifo;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       reset_n = 1'b1;
  logic       write = 1'b0;
  logic [0:0] write_vc = '0;
  logic [3:0] item_in = '0;
  logic       read = 1'b0;
  logic [0:0] read_vc = '0;
  logic [3:0] item_out;
  logic [1:0] full, empty, almost_full;
  logic       overflow, underflow;

  int n_assert = 0;
  int n_fail   = 0;

  vc_fifo dut (
    .clk(clk), .reset_n(reset_n),
    .write(write), .write_vc(write_vc), .item_in(item_in),
    .read(read), .read_vc(read_vc), .item_out(item_out),
    .full(full), .empty(empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = clk_en ? ~clk : 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one request set across a single posedge; outputs are sampled 1ns after it.
  task automatic op(input logic w, input logic [0:0] wv, input logic [3:0] d,
                    input logic r, input logic [0:0] rv);
    write = w; write_vc = wv; item_in = d; read = r; read_vc = rv;
    @(posedge clk);
    #1;
    write = 1'b0; read = 1'b0;
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'h3);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_flags", {30'd0, overflow, underflow}, 32'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    // 1: reset with the clock stopped
    #3 reset_n = 1'b0;
    #3;
    chk("t1_empty", 32'(empty), 32'h3);
    chk("t1_full", 32'(full), 32'h0);
    chk("t1_afull", 32'(almost_full), 32'h0);
    chk("t1_ovf", 32'(overflow), 32'h0);
    chk("t1_unf", 32'(underflow), 32'h0);
    chk("t1_item", 32'(item_out), 32'h0);
    #2 reset_n = 1'b1;
    #2 clk_en = 1'b1;
    @(negedge clk);

    // 2: fill VC0 with 1..8, overflow on 9th, drain in order
    for (int i = 1; i <= 8; i++) begin
      op(1'b1, 1'b0, 4'(i), 1'b0, 1'b0);
      chk("t2_head", 32'(item_out), 32'h1);
      chk("t2_afull", 32'(almost_full[0]), (i >= 6) ? 32'h1 : 32'h0);
      chk("t2_full", 32'(full[0]), (i == 8) ? 32'h1 : 32'h0);
    end
    chk("t2_empty_full", 32'(empty), 32'h2);
    op(1'b1, 1'b0, 4'h9, 1'b0, 1'b0);
    chk("t2_ovf", 32'(overflow), 32'h1);
    chk("t2_full_after_ovf", 32'(full), 32'h1);
    chk("t2_head_after_ovf", 32'(item_out), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      chk("t2_pop_val", 32'(item_out), 32'(i));
      op(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      chk("t2_afull_drain", 32'(almost_full[0]), (i <= 2) ? 32'h1 : 32'h0);
    end
    chk("t2_empty_drained", 32'(empty), 32'h3);
    chk("t2_item_empty", 32'(item_out), 32'h0);
    chk("t2_unf", 32'(underflow), 32'h0);

    // 3: pointer wrap on VC1
    for (int i = 1; i <= 5; i++) op(1'b1, 1'b1, 4'(i), 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      chk("t3_pre_val", 32'(item_out), 32'(i));
      op(1'b0, 1'b1, 4'h0, 1'b1, 1'b1);
    end
    chk("t3_empty_mid", 32'(empty), 32'h3);
    for (int i = 8; i <= 15; i++) op(1'b1, 1'b1, 4'(i), 1'b0, 1'b1);
    chk("t3_full", 32'(full), 32'h2);
    for (int i = 8; i <= 15; i++) begin
      chk("t3_wrap_val", 32'(item_out), 32'(i));
      op(1'b0, 1'b1, 4'h0, 1'b1, 1'b1);
    end
    chk("t3_empty_end", 32'(empty), 32'h3);

    // 4: same-edge push/pop on one channel
    async_reset();
    @(negedge clk);
    op(1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
    op(1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
    op(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
    op(1'b1, 1'b0, 4'h7, 1'b1, 1'b0);
    chk("t4_head_adv", 32'(item_out), 32'h2);
    chk("t4_ovf_none", 32'(overflow), 32'h0);
    op(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("t4_val3", 32'(item_out), 32'h3);
    op(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("t4_val7", 32'(item_out), 32'h7);
    op(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("t4_cnt3_empty", 32'(empty), 32'h3);
    for (int i = 1; i <= 8; i++) op(1'b1, 1'b0, 4'(i), 1'b0, 1'b0);
    op(1'b1, 1'b0, 4'h9, 1'b1, 1'b0);
    chk("t4_full_pp_ovf", 32'(overflow), 32'h1);
    chk("t4_full_pp_full", 32'(full), 32'h0);
    chk("t4_full_pp_afull", 32'(almost_full), 32'h1);
    chk("t4_full_pp_head", 32'(item_out), 32'h2);
    for (int i = 2; i <= 8; i++) begin
      chk("t4_drain7", 32'(item_out), 32'(i));
      op(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    end
    chk("t4_cnt7_empty", 32'(empty), 32'h3);

    // 5: cross-channel push/pop, underflow
    async_reset();
    @(negedge clk);
    op(1'b1, 1'b0, 4'h5, 1'b0, 1'b0);
    op(1'b1, 1'b0, 4'h6, 1'b0, 1'b0);
    op(1'b1, 1'b1, 4'hA, 1'b1, 1'b0);
    chk("t5_vc0_head", 32'(item_out), 32'h6);
    read_vc = 1'b1; #1;
    chk("t5_vc1_head", 32'(item_out), 32'hA);
    chk("t5_empty", 32'(empty), 32'h0);
    op(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("t5_vc0_empty", 32'(empty), 32'h1);
    op(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    chk("t5_both_empty", 32'(empty), 32'h3);
    chk("t5_unf_clear", 32'(underflow), 32'h0);
    op(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    chk("t5_unf", 32'(underflow), 32'h1);
    chk("t5_item_zero", 32'(item_out), 32'h0);
    chk("t5_ovf", 32'(overflow), 32'h0);

    // 6: async reset mid-burst with both channels half full
    async_reset();
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      op(1'b1, 1'b0, 4'(i), 1'b0, 1'b0);
      op(1'b1, 1'b1, 4'(i + 4), 1'b0, 1'b0);
    end
    chk("t6_half_empty", 32'(empty), 32'h0);
    write = 1'b1; write_vc = 1'b0; item_in = 4'hF;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_empty", 32'(empty), 32'h3);
    chk("t6_rst_item", 32'(item_out), 32'h0);
    chk("t6_rst_afull", 32'(almost_full), 32'h0);
    @(posedge clk); #1;
    chk("t6_held_empty", 32'(empty), 32'h3);
    write = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    op(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
    chk("t6_push_head", 32'(item_out), 32'h3);
    chk("t6_push_empty", 32'(empty), 32'h2);
    op(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("t6_pop_empty", 32'(empty), 32'h3);
    chk("t6_flags", {30'd0, overflow, underflow}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
